// File: rtl/uart_rx.sv
// uart_rx: oversampling UART receiver with runtime word length, parity and baud selection
module uart_rx #(
    parameter int CLK_HZ     = 4915200,
    parameter int OVERSAMPLE = 16
) (
    input  logic       clk,
    input  logic       resetn,
    input  logic       serial_data_in,
    input  logic [3:0] data_length,
    input  logic [1:0] parity_type,
    input  logic [1:0] baud_rate,
    output logic [7:0] data_out,
    output logic       data_valid,
    output logic       parity_error,
    output logic       framing_error,
    output logic       busy
);
    localparam int DIV0_RAW = CLK_HZ / (OVERSAMPLE * 4800);
    localparam int DIV1_RAW = CLK_HZ / (OVERSAMPLE * 9600);
    localparam int DIV2_RAW = CLK_HZ / (OVERSAMPLE * 19200);
    localparam int DIV3_RAW = CLK_HZ / (OVERSAMPLE * 38400);
    localparam int DIV0 = DIV0_RAW < 1 ? 1 : DIV0_RAW;
    localparam int DIV1 = DIV1_RAW < 1 ? 1 : DIV1_RAW;
    localparam int DIV2 = DIV2_RAW < 1 ? 1 : DIV2_RAW;
    localparam int DIV3 = DIV3_RAW < 1 ? 1 : DIV3_RAW;
    localparam int DW = $clog2(DIV0 + 1);
    localparam int TW = $clog2(OVERSAMPLE) + 1;
    localparam logic [TW-1:0] MID  = TW'(OVERSAMPLE / 2 - 1);
    localparam logic [TW-1:0] LAST = TW'(OVERSAMPLE - 1);

    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

    state_t        state, next_state;
    logic          rx_meta, rx, rx_prev;
    logic [DW-1:0] div_cnt, div_sel;
    logic [TW-1:0] tick_cnt;
    logic [2:0]    bit_cnt;
    logic [3:0]    len_q, len_clamped;
    logic [1:0]    par_q, baud_q;
    logic [7:0]    shift;
    logic          par_bit;
    logic          start_edge, tick, at_mid, at_end, last_bit, par_en;

    assign start_edge  = rx_prev & ~rx;
    assign div_sel     = baud_q == 2'd0 ? DW'(DIV0) :
                         baud_q == 2'd1 ? DW'(DIV1) :
                         baud_q == 2'd2 ? DW'(DIV2) : DW'(DIV3);
    assign tick        = (state != IDLE) && (div_cnt == div_sel - DW'(1));
    assign at_mid      = tick && (tick_cnt == MID);
    assign at_end      = tick && (tick_cnt == LAST);
    assign last_bit    = {1'b0, bit_cnt} == len_q - 4'd1;
    assign par_en      = ~par_q[1];
    assign len_clamped = data_length < 4'd5 ? 4'd5 : data_length > 4'd8 ? 4'd8 : data_length;
    assign busy        = state != IDLE;

    // two-flop synchronizer plus one delayed copy for falling-edge detection
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            rx_meta <= 1'b1;
            rx      <= 1'b1;
            rx_prev <= 1'b1;
        end else begin
            rx_meta <= serial_data_in;
            rx      <= rx_meta;
            rx_prev <= rx;
        end
    end

    // state register
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) state <= IDLE;
        else         state <= next_state;
    end

    // next-state: each bit is judged only at its sample tick
    always_comb begin
        next_state = state;
        case (state)
            IDLE:    next_state = start_edge ? START : IDLE;
            START:   next_state = at_mid ? (rx ? IDLE : DATA) : START;
            DATA:    next_state = (at_end && last_bit) ? (par_en ? PARITY : STOP) : DATA;
            PARITY:  next_state = at_end ? STOP : PARITY;
            STOP:    next_state = at_end ? IDLE : STOP;
            default: next_state = IDLE;
        endcase
    end

    // baud/sample counters, frame settings latch and bit capture
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            div_cnt  <= '0;
            tick_cnt <= '0;
            bit_cnt  <= '0;
            len_q    <= 4'd8;
            par_q    <= 2'd2;
            baud_q   <= 2'd0;
            shift    <= '0;
            par_bit  <= 1'b0;
        end else begin
            div_cnt <= (state == IDLE || tick) ? '0 : div_cnt + DW'(1);
            if (state == IDLE || at_end || (state == START && at_mid)) tick_cnt <= '0;
            else if (tick)                                             tick_cnt <= tick_cnt + TW'(1);
            if (state == IDLE && start_edge) begin
                len_q   <= len_clamped;
                par_q   <= parity_type;
                baud_q  <= baud_rate;
                shift   <= '0;
                bit_cnt <= '0;
            end
            if (state == DATA && at_end) begin
                shift[bit_cnt] <= rx;
                bit_cnt        <= bit_cnt + 3'd1;
            end
            if (state == PARITY && at_end) par_bit <= rx;
        end
    end

    // result registers update together with the data_valid pulse and then hold
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            data_out      <= '0;
            data_valid    <= 1'b0;
            parity_error  <= 1'b0;
            framing_error <= 1'b0;
        end else begin
            data_valid <= (state == STOP) && at_end;
            if (state == STOP && at_end) begin
                data_out      <= shift;
                parity_error  <= par_en & (^shift ^ par_bit ^ par_q[0]);
                framing_error <= ~rx;
            end
        end
    end
endmodule

// File: tb/tb_uart_rx.sv
// tb_uart_rx: directed frames from a serial driver model, checked against a scoreboard
module tb_uart_rx;
    typedef struct packed {
        logic [7:0] d;
        logic       pe;
        logic       fe;
    } exp_t;

    logic       clk = 1'b0;
    logic       resetn = 1'b0;
    logic       serial_data_in = 1'b1;
    logic [3:0] data_length = 4'd8;
    logic [1:0] parity_type = 2'd2;
    logic [1:0] baud_rate = 2'd3;
    logic [7:0] data_out;
    logic       data_valid, parity_error, framing_error, busy;

    exp_t sb[$];
    int   vectors = 0;
    int   errors = 0;
    int   cyc = 0;
    int   vcount = 0;
    int   last_valid_cyc = 0;
    int   tx_start_cyc = 0;
    logic dv_prev = 1'b0;

    uart_rx dut (
        .clk(clk), .resetn(resetn), .serial_data_in(serial_data_in),
        .data_length(data_length), .parity_type(parity_type), .baud_rate(baud_rate),
        .data_out(data_out), .data_valid(data_valid), .parity_error(parity_error),
        .framing_error(framing_error), .busy(busy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] want);
        vectors++;
        assert (obs === want) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, want);
        end
    endtask

    // output monitor: every data_valid pulse must match the oldest expected frame
    always @(negedge clk) begin
        exp_t e;
        if (data_valid) begin
            vcount++;
            last_valid_cyc = cyc;
            check("dv_one_cycle", {31'd0, dv_prev}, 32'd0);
            check("dv_expected", {31'd0, sb.size() != 0}, 32'd1);
            if (sb.size() != 0) begin
                e = sb.pop_front();
                check("data_out", {24'd0, data_out}, {24'd0, e.d});
                check("parity_error", {31'd0, parity_error}, {31'd0, e.pe});
                check("framing_error", {31'd0, framing_error}, {31'd0, e.fe});
            end
        end
        dv_prev = data_valid;
    end

    task automatic drive_bit(input logic b, input int n);
        serial_data_in = b;
        repeat (n) @(negedge clk);
    endtask

    task automatic wait_clks(input int n);
        repeat (n) @(negedge clk);
    endtask

    // serial driver: pushes the expected result, then sends the frame; line is left at the stop level
    task automatic frame(input logic [7:0] d, input logic [3:0] len, input logic [1:0] pt,
                         input logic [1:0] br, input logic stop, input logic flip);
        int n, bc;
        logic [7:0] m;
        logic p;
        exp_t e;
        n  = len < 5 ? 5 : len > 8 ? 8 : int'(len);
        m  = d & 8'(((1 << n) - 1));
        p  = ^m ^ (pt == 2'd1) ^ flip;
        bc = 128 << (3 - br);
        @(negedge clk);
        data_length = len;
        parity_type = pt;
        baud_rate   = br;
        e.d  = m;
        e.pe = (pt < 2'd2) & flip;
        e.fe = ~stop;
        sb.push_back(e);
        tx_start_cyc = cyc;
        drive_bit(1'b0, bc);
        for (int i = 0; i < n; i++) drive_bit(m[i], bc);
        if (pt < 2'd2) drive_bit(p, bc);
        drive_bit(stop, bc);
    endtask

    task automatic drained(input string tag);
        wait_clks(20);
        check(tag, sb.size(), 32'd0);
    endtask

    initial begin
        #1000000;
        $display("FAIL timeout: simulation did not finish in time");
        $fatal(1, "timeout");
    end

    initial begin
        int v0, bc, dur;
        wait_clks(3);
        check("rst_data_out", {24'd0, data_out}, 32'd0);
        check("rst_data_valid", {31'd0, data_valid}, 32'd0);
        check("rst_parity_error", {31'd0, parity_error}, 32'd0);
        check("rst_framing_error", {31'd0, framing_error}, 32'd0);
        check("rst_busy", {31'd0, busy}, 32'd0);
        resetn = 1'b1;
        wait_clks(10);

        frame(8'h81, 4'd8, 2'd0, 2'd3, 1'b1, 1'b0);
        drained("even_ok_drain");
        frame(8'h81, 4'd8, 2'd0, 2'd3, 1'b1, 1'b1);
        drained("even_bad_drain");
        check("perr_held", {31'd0, parity_error}, 32'd1);
        frame(8'h83, 4'd8, 2'd1, 2'd3, 1'b1, 1'b0);
        drained("odd_ok_drain");
        frame(8'h83, 4'd8, 2'd1, 2'd3, 1'b1, 1'b1);
        drained("odd_bad_drain");

        v0 = vcount;
        frame(8'h01, 4'd8, 2'd2, 2'd3, 1'b1, 1'b0);
        frame(8'h03, 4'd8, 2'd3, 2'd3, 1'b1, 1'b0);
        drained("b2b_drain");
        check("b2b_pulses", vcount - v0, 32'd2);

        frame(8'hFF, 4'd5, 2'd2, 2'd3, 1'b1, 1'b0);
        drained("len5_drain");
        frame(8'hFF, 4'd6, 2'd2, 2'd3, 1'b1, 1'b0);
        drained("len6_drain");
        frame(8'hFF, 4'd7, 2'd2, 2'd3, 1'b1, 1'b0);
        drained("len7_drain");
        frame(8'hFF, 4'd8, 2'd2, 2'd3, 1'b1, 1'b0);
        drained("len8_drain");
        frame(8'hFF, 4'd3, 2'd2, 2'd3, 1'b1, 1'b0);
        drained("len3_drain");
        frame(8'hFF, 4'd12, 2'd0, 2'd3, 1'b1, 1'b0);
        drained("len12_drain");

        v0 = vcount;
        drive_bit(1'b0, 4);
        drive_bit(1'b1, 10);
        check("glitch_busy_start", {31'd0, busy}, 32'd1);
        wait_clks(200);
        check("glitch_busy_idle", {31'd0, busy}, 32'd0);
        check("glitch_no_dv", vcount - v0, 32'd0);

        frame(8'h55, 4'd8, 2'd2, 2'd3, 1'b0, 1'b0);
        serial_data_in = 1'b1;
        drained("ferr_drain");
        check("ferr_held", {31'd0, framing_error}, 32'd1);

        frame(8'h00, 4'd8, 2'd2, 2'd3, 1'b0, 1'b0);
        v0 = vcount;
        wait_clks(3 * 128);
        check("break_no_frames", vcount - v0, 32'd0);
        check("break_idle", {31'd0, busy}, 32'd0);
        serial_data_in = 1'b1;
        drained("break_drain");

        frame(8'h5A, 4'd8, 2'd2, 2'd3, 1'b1, 1'b0);
        drained("pre_rst_drain");
        v0 = vcount;
        drive_bit(1'b0, 128);
        drive_bit(1'b1, 200);
        check("mid_data_busy", {31'd0, busy}, 32'd1);
        resetn = 1'b0;
        wait_clks(2);
        check("mid_rst_data_out", {24'd0, data_out}, 32'd0);
        check("mid_rst_data_valid", {31'd0, data_valid}, 32'd0);
        check("mid_rst_parity_error", {31'd0, parity_error}, 32'd0);
        check("mid_rst_framing_error", {31'd0, framing_error}, 32'd0);
        check("mid_rst_busy", {31'd0, busy}, 32'd0);
        wait_clks(8);
        resetn = 1'b1;
        wait_clks(1500);
        check("rst_abort_no_dv", vcount - v0, 32'd0);
        check("rst_abort_idle", {31'd0, busy}, 32'd0);
        frame(8'hA5, 4'd8, 2'd2, 2'd3, 1'b1, 1'b0);
        drained("after_rst_drain");

        for (int b = 0; b < 4; b++) begin
            v0 = vcount;
            bc = 128 << (3 - b);
            fork
                frame(8'h3C, 4'd8, 2'd2, 2'(b), 1'b1, 1'b0);
                begin
                    wait_clks(300);
                    data_length = 4'd5;
                    parity_type = 2'd0;
                    baud_rate   = 2'(3 - b);
                end
            join
            drained("loop_drain");
            check("loop_pulse", vcount - v0, 32'd1);
            dur = last_valid_cyc - tx_start_cyc;
            check("loop_duration", {31'd0, (dur >= 8 * bc + bc / 2) && (dur <= 10 * bc + bc / 2)}, 32'd1);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end
endmodule
